mipi_packet_deframer: RTL and testbench

Parametrised successor to the MIPI receive verifier. It sits on the `rx_pixel_clk` domain directly after the MIPI RX IP and consumes 48-bit pixel beats qualified by `my_mipi_rx_VALID`. It frames packets as SOF/ID beat, header beat, payload beats and an optional checksum beat. Each good payload is delivered as a right-aligned, half-swapped word with a one-cycle strobe; length, checksum and stall-timeout errors are flagged.

---
 rtl/mipi_packet_deframer.sv | 177 +++++++++++++++++
 tb/tb_mipi_packet_deframer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_packet_deframer.sv
// mipi_packet_deframer
// Frames SOF/ID, header and payload beats arriving from the MIPI RX IP on
// rx_pixel_clk. Each good payload is delivered right-aligned and half-swapped,
// with a one-cycle data_valid strobe. Length and stall-timeout errors are
// flagged with one-cycle strobes.
// Optional trailing checksum beat: define DEFRAMER_CSUM_EN.
module mipi_packet_deframer #(
    parameter int          MAX_BYTES = 48,
    parameter logic [23:0] SOF       = 24'hEAFF99,
    parameter int          TIMEOUT   = 1024
) (
    input  logic                   rx_pixel_clk,
    input  logic                   rst_n,
    input  logic [47:0]            packet,
    input  logic                   my_mipi_rx_VALID,
    output logic [MAX_BYTES*8-1:0] data,
    output logic [31:0]            data_len,
    output logic [7:0]             dtype,
    output logic [23:0]            pkt_id,
    output logic [7:0]             phl_id,
    output logic                   data_valid,
    output logic                   err_len,
    output logic                   err_csum,
    output logic                   err_timeout,
    output logic                   busy
);

    localparam int MAX_BEATS = MAX_BYTES / 6;
    localparam int DW        = MAX_BYTES * 8;
    localparam int CW        = $clog2(MAX_BEATS + 1);
    localparam int TW        = $clog2(TIMEOUT);    // timer only ever holds 0..TIMEOUT-1

`ifdef DEFRAMER_CSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

    state_t        state;
    logic [23:0]   id_q;
    logic [7:0]    dtype_q;
    logic [31:0]   dlen_q;
    logic [7:0]    phl_q;
    logic [CW-1:0] n_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] shreg;
    logic [TW-1:0] timer;
`ifdef DEFRAMER_CSUM_EN
    logic [47:0]   csum_q;
`endif

    logic [31:0]   hdr_dlen;
    logic          len_bad;
    logic [CW-1:0] n_calc;
    logic [CW-1:0] cnt_next;
    logic          last_beat;
    logic [DW-1:0] shreg_next;

    // Header decode, beat target and the next shift-register value.
    always_comb begin
        hdr_dlen   = packet[39:8];
        len_bad    = (hdr_dlen == 32'd0) || (hdr_dlen > 32'(MAX_BYTES));
        n_calc     = CW'((hdr_dlen + 32'd5) / 32'd6);
        cnt_next   = cnt_q + CW'(1);
        last_beat  = (cnt_next == n_q);
        shreg_next = (shreg << 48) | DW'({packet[23:0], packet[47:24]});
    end

    assign busy = (state != IDLE);

`ifndef DEFRAMER_CSUM_EN
    assign err_csum = 1'b0;
`endif

    // Framing FSM with stall timer; all outputs registered.
    always_ff @(posedge rx_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            id_q        <= '0;
            dtype_q     <= '0;
            dlen_q      <= '0;
            phl_q       <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            shreg       <= '0;
            timer       <= '0;
            data        <= '0;
            data_len    <= '0;
            dtype       <= '0;
            pkt_id      <= '0;
            phl_id      <= '0;
            data_valid  <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
`ifdef DEFRAMER_CSUM_EN
            csum_q      <= '0;
            err_csum    <= 1'b0;
`endif
        end else begin
            data_valid  <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
`ifdef DEFRAMER_CSUM_EN
            err_csum    <= 1'b0;
`endif
            if (state == IDLE) begin
                timer <= '0;
                if (my_mipi_rx_VALID && (packet[47:24] == SOF)) begin
                    id_q  <= packet[23:0];
                    state <= HDR;
                end
            end else if (my_mipi_rx_VALID) begin
                timer <= '0;
                case (state)
                    HDR: begin
                        dtype_q <= packet[47:40];
                        dlen_q  <= hdr_dlen;
                        phl_q   <= packet[7:0];
                        if (len_bad) begin
                            err_len <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            n_q    <= n_calc;
                            cnt_q  <= '0;
                            shreg  <= '0;
`ifdef DEFRAMER_CSUM_EN
                            csum_q <= '0;
`endif
                            state  <= PAY;
                        end
                    end
                    PAY: begin
                        shreg <= shreg_next;
                        cnt_q <= cnt_next;
`ifdef DEFRAMER_CSUM_EN
                        csum_q <= csum_q ^ packet;
                        if (last_beat) state <= CSUM;
`else
                        if (last_beat) begin
                            data       <= shreg_next;
                            data_len   <= dlen_q;
                            dtype      <= dtype_q;
                            pkt_id     <= id_q;
                            phl_id     <= phl_q;
                            data_valid <= 1'b1;
                            state      <= IDLE;
                        end
`endif
                    end
`ifdef DEFRAMER_CSUM_EN
                    CSUM: begin
                        if (packet == csum_q) begin
                            data       <= shreg;
                            data_len   <= dlen_q;
                            dtype      <= dtype_q;
                            pkt_id     <= id_q;
                            phl_id     <= phl_q;
                            data_valid <= 1'b1;
                        end else begin
                            err_csum   <= 1'b1;
                        end
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end else if (timer == TW'(TIMEOUT - 1)) begin
                err_timeout <= 1'b1;
                timer       <= '0;
                state       <= IDLE;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mipi_packet_deframer.sv
// tb_mipi_packet_deframer
// Directed bench for mipi_packet_deframer (MAX_BYTES=48, TIMEOUT=16).
// Checksum scenarios are included when DEFRAMER_CSUM_EN is defined.
`ifdef DEFRAMER_CSUM_EN
`define TAIL(cs) beat(cs);
`else
`define TAIL(cs)
`endif

module tb_mipi_packet_deframer;

    localparam int DW  = 384;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [47:0]   packet;
    logic          valid;
    logic [DW-1:0] data;
    logic [31:0]   data_len;
    logic [7:0]    dtype;
    logic [23:0]   pkt_id;
    logic [7:0]    phl_id;
    logic          data_valid, err_len, err_csum, err_timeout, busy;

    int n_total = 0;
    int n_pass  = 0;
    int dv_cnt = 0, el_cnt = 0, ec_cnt = 0, et_cnt = 0;

    logic [DW-1:0] exp_data;
    logic [31:0]   exp_len;
    logic [7:0]    exp_dtype;
    logic [23:0]   exp_id;
    logic [7:0]    exp_phl;
    logic [47:0]   acc_cs;
    logic [47:0]   p;

    mipi_packet_deframer #(.MAX_BYTES(48), .SOF(24'hEAFF99), .TIMEOUT(TMO)) dut (
        .rx_pixel_clk    (clk),
        .rst_n           (rst_n),
        .packet          (packet),
        .my_mipi_rx_VALID(valid),
        .data            (data),
        .data_len        (data_len),
        .dtype           (dtype),
        .pkt_id          (pkt_id),
        .phl_id          (phl_id),
        .data_valid      (data_valid),
        .err_len         (err_len),
        .err_csum        (err_csum),
        .err_timeout     (err_timeout),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Strobe counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (data_valid)  dv_cnt++;
        if (err_len)     el_cnt++;
        if (err_csum)    ec_cnt++;
        if (err_timeout) et_cnt++;
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag);
        chk({tag, " data"},     data,                exp_data);
        chk({tag, " data_len"}, DW'(data_len),       DW'(exp_len));
        chk({tag, " dtype"},    DW'(dtype),          DW'(exp_dtype));
        chk({tag, " pkt_id"},   DW'(pkt_id),         DW'(exp_id));
        chk({tag, " phl_id"},   DW'(phl_id),         DW'(exp_phl));
    endtask

    // Present one accepted beat; returns at the following falling edge.
    task automatic beat(input logic [47:0] b);
        packet = b;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic zero_counts();
        dv_cnt = 0; el_cnt = 0; ec_cnt = 0; et_cnt = 0;
    endtask

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        packet = '0;
        @(negedge clk);
        exp_data = '0; exp_len = '0; exp_dtype = '0; exp_id = '0; exp_phl = '0;
        chk_out("reset");
        chk("reset data_valid", DW'(data_valid), '0);
        chk("reset err_len",    DW'(err_len), '0);
        chk("reset err_timeout", DW'(err_timeout), '0);
        chk("reset busy",       DW'(busy), '0);
        rst_n = 1'b1;
        idle(1);
        zero_counts();

        // Packet A: 12 bytes, two payload beats.
        beat(48'hEAFF99_000123);
        chk("A busy after SOF", DW'(busy), DW'(1));
        beat(48'h07_0000000C_5A);
        beat(48'h111111_222222);
        chk("A no strobe mid", DW'(data_valid), '0);
        beat(48'h333333_444444);
        `TAIL(48'h222222_666666)
        chk("A data_valid", DW'(data_valid), DW'(1));
        exp_data = DW'(96'h222222111111_444444333333);
        exp_len = 32'd12; exp_dtype = 8'h07; exp_id = 24'h000123; exp_phl = 8'h5A;
        chk_out("A");
        chk("A busy after", DW'(busy), '0);
        idle(1);
        chk("A strobe one cycle", DW'(data_valid), '0);
        chk("A dv count", DW'(dv_cnt), DW'(1));
        zero_counts();

        // Packet B: same payload with a 5-cycle VALID gap.
        beat(48'hEAFF99_000456);
        beat(48'h07_0000000C_5A);
        beat(48'h111111_222222);
        idle(5);
        chk("B no strobe in gap", DW'(data_valid), '0);
        chk("B busy in gap", DW'(busy), DW'(1));
        beat(48'h333333_444444);
        `TAIL(48'h222222_666666)
        chk("B data_valid", DW'(data_valid), DW'(1));
        exp_id = 24'h000456;
        chk_out("B");
        idle(1);
        chk("B dv count", DW'(dv_cnt), DW'(1));
        chk("B no errors", DW'(el_cnt + ec_cnt + et_cnt), '0);
        zero_counts();

        // dlen=49 rejected, then back-to-back dlen=6 packet.
        beat(48'hEAFF99_000777);
        beat(48'h07_00000031_00);
        chk("len49 err_len", DW'(err_len), DW'(1));
        chk("len49 busy", DW'(busy), '0);
        chk_out("len49 hold");
        beat(48'hEAFF99_000789);
        chk("len49 err one cycle", DW'(err_len), '0);
        beat(48'h01_00000006_11);
        beat(48'hAABBCC_DDEEFF);
        `TAIL(48'hAABBCC_DDEEFF)
        chk("len6 data_valid", DW'(data_valid), DW'(1));
        exp_data = DW'(48'hDDEEFF_AABBCC);
        exp_len = 32'd6; exp_dtype = 8'h01; exp_id = 24'h000789; exp_phl = 8'h11;
        chk_out("len6");

        // dlen=0 rejected.
        beat(48'hEAFF99_000999);
        beat(48'h07_00000000_00);
        chk("len0 err_len", DW'(err_len), DW'(1));
        chk_out("len0 hold");

        // dlen=48: full eight-beat payload.
        beat(48'hEAFF99_00ABCD);
        beat(48'h03_00000030_33);
        exp_data = '0;
        acc_cs = '0;
        for (int i = 0; i < 8; i++) begin
            p = {24'h100000 + 24'(i), 24'hA00000 + 24'(i)};
            exp_data = (exp_data << 48) | DW'({p[23:0], p[47:24]});
            acc_cs = acc_cs ^ p;
            beat(p);
        end
        `TAIL(acc_cs)
        chk("len48 data_valid", DW'(data_valid), DW'(1));
        exp_len = 32'd48; exp_dtype = 8'h03; exp_id = 24'h00ABCD; exp_phl = 8'h33;
        chk_out("len48");
        idle(1);
        zero_counts();

        // Stall timeout after the header.
        beat(48'hEAFF99_000AAA);
        beat(48'h07_0000000C_5A);
        idle(TMO - 1);
        chk("tmo not yet", DW'(err_timeout), '0);
        chk("tmo busy before", DW'(busy), DW'(1));
        idle(1);
        chk("tmo err_timeout", DW'(err_timeout), DW'(1));
        chk("tmo busy falls", DW'(busy), '0);
        chk_out("tmo hold");
        idle(1);
        chk("tmo strobe count", DW'(et_cnt), DW'(1));
        chk("tmo no dv", DW'(dv_cnt), '0);
        zero_counts();

`ifdef DEFRAMER_CSUM_EN
        // Checksum mismatch.
        beat(48'hEAFF99_000BBB);
        beat(48'h07_0000000C_5A);
        beat(48'h111111_222222);
        beat(48'h333333_444444);
        beat(48'h222222_666667);
        chk("csum err_csum", DW'(err_csum), DW'(1));
        chk("csum no dv", DW'(data_valid), '0);
        chk_out("csum hold");
        idle(1);
        chk("csum counts", DW'(ec_cnt), DW'(1));
        zero_counts();
`endif

        // Reset asserted mid-PAY.
        beat(48'hEAFF99_000CCC);
        beat(48'h07_0000000C_5A);
        beat(48'h111111_222222);
        #2 rst_n = 1'b0;
        #1;
        exp_data = '0; exp_len = '0; exp_dtype = '0; exp_id = '0; exp_phl = '0;
        chk_out("rst async");
        chk("rst busy", DW'(busy), '0);
        chk("rst data_valid", DW'(data_valid), '0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        beat(48'hEAFF99_000123);
        beat(48'h07_0000000C_5A);
        beat(48'h111111_222222);
        beat(48'h333333_444444);
        `TAIL(48'h222222_666666)
        chk("post-rst data_valid", DW'(data_valid), DW'(1));
        exp_data = DW'(96'h222222111111_444444333333);
        exp_len = 32'd12; exp_dtype = 8'h07; exp_id = 24'h000123; exp_phl = 8'h5A;
        chk_out("post-rst");
        chk("err_csum idle", DW'(err_csum), '0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
